// File: rtl/trigger_window_reader.sv
// Reads a pre/post-trigger window of samples out of the circular acquisition
// buffer with single-beat reads and streams them on an AXI-Stream master.

module trigger_window_reader #(
  parameter int unsigned                DATA_WIDTH      = 16,
  parameter int unsigned                MEMORY_ADDR_LEN = 32,
  parameter int unsigned                SAMPLE_BYTES    = 2,
  parameter logic [MEMORY_ADDR_LEN-1:0] BUF_BASE        = 32'h0000_1000,
  parameter int unsigned                BUF_SIZE        = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MEMORY_ADDR_LEN-1:0] trigger_addr,
  input  logic [15:0]                pre_samples,
  input  logic [15:0]                post_samples,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       rd_req,
  output logic [MEMORY_ADDR_LEN-1:0] rd_addr,
  input  logic                       rd_ready,
  input  logic                       rd_data_valid,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  localparam int unsigned AW = MEMORY_ADDR_LEN;
  localparam logic [AW-1:0] SIZE_A   = AW'(BUF_SIZE);
  localparam logic [AW-1:0] STEP_A   = AW'(SAMPLE_BYTES);
  localparam logic [AW-1:0] BUF_END  = BUF_BASE + SIZE_A;
  localparam logic [AW-1:0] OFS_MASK = SIZE_A - {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         trig_q, trig_d;
  logic [15:0]           pre_q, pre_d;
  logic [15:0]           post_q, post_d;
  logic [16:0]           remaining_q, remaining_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  logic [16:0]   total_s;
  logic [AW-1:0] win_bytes_s;
  logic [AW-1:0] pre_bytes_s;
  logic [AW-1:0] offset_s;
  logic [AW-1:0] addr_inc_s;
  logic          addr_ok_s;
  logic          size_ok_s;
  logic          slot_free_s;

  assign total_s     = {1'b0, pre_q} + {1'b0, post_q};
  assign win_bytes_s = AW'(total_s) * STEP_A;
  assign pre_bytes_s = AW'(pre_q) * STEP_A;
  assign addr_ok_s   = (trig_q >= BUF_BASE) && (trig_q < BUF_END);
  assign size_ok_s   = (win_bytes_s <= SIZE_A);
  // Masking by BUF_SIZE-1 folds a window that starts below the base back into the buffer.
  assign offset_s    = (trig_q - BUF_BASE - pre_bytes_s) & OFS_MASK;
  assign addr_inc_s  = rd_addr_q + STEP_A;

  // A read may only be issued when its response is guaranteed a place in the output slot.
  assign slot_free_s = !tvalid_q || m_axis_tready;
  assign rd_req      = (state_q == S_REQ) && slot_free_s;

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rd_addr       = rd_addr_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  // Next-state and output-register computation for the window reader FSM.
  always_comb begin
    state_d     = state_q;
    trig_d      = trig_q;
    pre_d       = pre_q;
    post_d      = post_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_addr_d   = rd_addr_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse belongs to the previous request.
        if (start && !done_q) begin
          trig_d  = trigger_addr;
          pre_d   = pre_samples;
          post_d  = post_samples;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (!addr_ok_s || !size_ok_s) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (total_s == 17'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          rd_addr_d   = BUF_BASE + offset_s;
          remaining_d = total_s;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_req && rd_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (rd_data_valid) begin
          tdata_d     = rd_data;
          tvalid_d    = 1'b1;
          tlast_d     = (remaining_q == 17'd1);
          remaining_d = remaining_q - 17'd1;
          if (addr_inc_s == BUF_END) begin
            rd_addr_d = BUF_BASE;
          end else begin
            rd_addr_d = addr_inc_s;
          end
          if (remaining_q > 17'd1) begin
            state_d = S_REQ;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (tvalid_q && m_axis_tready && tlast_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any window in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_q      <= {AW{1'b0}};
      pre_q       <= 16'd0;
      post_q      <= 16'd0;
      remaining_q <= 17'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_addr_q   <= {AW{1'b0}};
      tdata_q     <= {DATA_WIDTH{1'b0}};
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_addr_q   <= rd_addr_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

endmodule

// File: tb/tb_trigger_window_reader.sv
// Scoreboard bench for trigger_window_reader: expected reads, beats and done/err
// responses are queued at stimulus time and checked by independent monitors.

module tb_trigger_window_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] trigger_addr;
  logic [15:0] pre_samples;
  logic [15:0] post_samples;
  logic        busy, done, err, rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_data_valid;
  logic [15:0] rd_data;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  always #5 clk = ~clk;

  trigger_window_reader dut (
    .clk(clk), .rst(rst), .start(start), .trigger_addr(trigger_addr),
    .pre_samples(pre_samples), .post_samples(post_samples),
    .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] addr_q[$];
  logic [16:0] beat_q[$];
  logic        err_q[$];
  int          beat_cnt = 0;
  int          read_cnt = 0;
  int          done_cnt = 0;
  logic        hold_en = 1'b0;
  int          hold_idx = 0;
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'd0;

  function automatic logic [15:0] mem_fn(input logic [31:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_read(input logic [31:0] a, input logic last);
    addr_q.push_back(a);
    beat_q.push_back({last, mem_fn(a)});
  endtask

  task automatic pulse_start(input logic [31:0] t, input logic [15:0] pr, input logic [15:0] po);
    @(posedge clk); #1;
    start = 1'b1; trigger_addr = t; pre_samples = pr; post_samples = po;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((err_q.size() != 0 || beat_q.size() != 0) && n < 2000) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required=completion", name, n);
    end
    @(posedge clk); #1;
    chk({name, "_addr_left"}, 64'(addr_q.size()), 64'd0);
    chk({name, "_busy_after"}, {63'd0, busy}, 64'd0);
  endtask

  // Memory model: one response, one cycle after accept, optionally held back.
  initial begin
    rd_data_valid = 1'b0;
    rd_data       = 16'd0;
    rd_ready      = 1'b1;
    forever begin
      @(negedge clk);
      rd_data_valid = 1'b0;
      if (mem_pending) begin
        if (!(hold_en && read_cnt == hold_idx)) begin
          rd_data_valid = 1'b1;
          rd_data       = mem_fn(mem_addr);
          mem_pending   = 1'b0;
        end
      end else if (!rst && rd_req && rd_ready) begin
        read_cnt++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_req_unexpected actual=%0h required=no request", rd_addr);
        end else begin
          chk("rd_addr", rd_addr, addr_q.pop_front());
        end
        mem_pending = 1'b1;
        mem_addr    = rd_addr;
      end
    end
  end

  // Stream and completion monitor.
  initial begin
    logic [16:0] exp_b;
    forever begin
      @(negedge clk);
      if (!rst && m_axis_tvalid && m_axis_tready) begin
        beat_cnt++;
        if (beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected actual=%0h required=no beat", m_axis_tdata);
        end else begin
          exp_b = beat_q.pop_front();
          chk("tdata", m_axis_tdata, exp_b[15:0]);
          chk("tlast", m_axis_tlast, exp_b[16]);
        end
      end
      if (!rst && done) begin
        done_cnt++;
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          chk("err", err, err_q.pop_front());
        end
      end else if (!rst && err) begin
        checks++; errors++;
        $display("FAIL err_without_done actual=1 required=0");
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"},   busy, 1'b0);
    chk({name, "_done"},   done, 1'b0);
    chk({name, "_err"},    err, 1'b0);
    chk({name, "_rd_req"}, rd_req, 1'b0);
    chk({name, "_rd_addr"}, rd_addr, 32'd0);
    chk({name, "_tdata"},  m_axis_tdata, 16'd0);
    chk({name, "_tvalid"}, m_axis_tvalid, 1'b0);
    chk({name, "_tlast"},  m_axis_tlast, 1'b0);
  endtask

  initial begin
    int d0, r0, b0, n;
    logic [15:0] held;
    rst = 1'b1; start = 1'b0; trigger_addr = 32'd0;
    pre_samples = 16'd0; post_samples = 16'd0; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Basic window: trigger 0x1010, 4 before, 4 from trigger.
    push_read(32'h1008, 1'b0); push_read(32'h100A, 1'b0);
    push_read(32'h100C, 1'b0); push_read(32'h100E, 1'b0);
    push_read(32'h1010, 1'b0); push_read(32'h1012, 1'b0);
    push_read(32'h1014, 1'b0); push_read(32'h1016, 1'b1);
    err_q.push_back(1'b0);
    d0 = done_cnt; r0 = read_cnt;
    pulse_start(32'h1010, 16'd4, 16'd4);
    chk("busy_rise", busy, 1'b1);
    chk("rd_req_in_setup", rd_req, 1'b0);
    @(posedge clk); #1;
    chk("rd_req_rise", rd_req, 1'b1);
    wait_done("basic");
    chk("basic_done_count", 64'(done_cnt - d0), 64'd1);
    chk("basic_reads", 64'(read_cnt - r0), 64'd8);

    // Window starting below the base wraps to the top of the buffer.
    push_read(32'h10FC, 1'b0); push_read(32'h10FE, 1'b0);
    push_read(32'h1000, 1'b0); push_read(32'h1002, 1'b0);
    push_read(32'h1004, 1'b1);
    err_q.push_back(1'b0);
    pulse_start(32'h1002, 16'd3, 16'd2);
    wait_done("wrap");

    // Backpressure: first beat stalls for 20 cycles.
    push_read(32'h107C, 1'b0); push_read(32'h107E, 1'b0);
    push_read(32'h1080, 1'b0); push_read(32'h1082, 1'b0);
    push_read(32'h1084, 1'b0); push_read(32'h1086, 1'b0);
    push_read(32'h1088, 1'b0); push_read(32'h108A, 1'b1);
    err_q.push_back(1'b0);
    m_axis_tready = 1'b0;
    pulse_start(32'h1080, 16'd2, 16'd6);
    n = 0;
    while (!m_axis_tvalid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_first_beat_seen", m_axis_tvalid, 1'b1);
    held = m_axis_tdata;
    chk("bp_first_data", held, mem_fn(32'h107C));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_tvalid_hold", m_axis_tvalid, 1'b1);
      chk("bp_tdata_hold", m_axis_tdata, held);
      chk("bp_no_rd_req", rd_req, 1'b0);
    end
    m_axis_tready = 1'b1;
    wait_done("backpressure");

    // Rejected and empty requests.
    r0 = read_cnt;
    err_q.push_back(1'b1);
    pulse_start(32'h1010, 16'd100, 16'd29);
    wait_done("too_long");
    err_q.push_back(1'b1);
    pulse_start(32'h2000, 16'd4, 16'd4);
    wait_done("addr_far");
    err_q.push_back(1'b1);
    pulse_start(32'h1100, 16'd1, 16'd1);
    wait_done("addr_end");
    d0 = done_cnt;
    err_q.push_back(1'b0);
    pulse_start(32'h1010, 16'd0, 16'd0);
    wait_done("empty");
    chk("empty_done_count", 64'(done_cnt - d0), 64'd1);
    chk("reject_no_reads", 64'(read_cnt - r0), 64'd0);

    // Reset with the fourth read outstanding, then a late response.
    push_read(32'h1038, 1'b0); push_read(32'h103A, 1'b0);
    push_read(32'h103C, 1'b0); push_read(32'h103E, 1'b0);
    push_read(32'h1040, 1'b0); push_read(32'h1042, 1'b0);
    push_read(32'h1044, 1'b0); push_read(32'h1046, 1'b1);
    err_q.push_back(1'b0);
    r0 = read_cnt; b0 = beat_cnt; d0 = done_cnt;
    hold_idx = r0 + 4; hold_en = 1'b1;
    pulse_start(32'h1040, 16'd4, 16'd4);
    n = 0;
    while (beat_cnt < b0 + 3 && n < 200) begin @(posedge clk); #1; n++; end
    chk("rst_three_beats", 64'(beat_cnt - b0), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_outstanding", 64'(read_cnt - r0), 64'd4);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    addr_q.delete(); beat_q.delete(); err_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; hold_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("late_tvalid", m_axis_tvalid, 1'b0);
      chk("late_busy", busy, 1'b0);
    end
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);

    // Full window after reset, wrapping upward past the buffer end.
    push_read(32'h10F6, 1'b0); push_read(32'h10F8, 1'b0);
    push_read(32'h10FA, 1'b0); push_read(32'h10FC, 1'b0);
    push_read(32'h10FE, 1'b0); push_read(32'h1000, 1'b0);
    push_read(32'h1002, 1'b0); push_read(32'h1004, 1'b0);
    push_read(32'h1006, 1'b1);
    err_q.push_back(1'b0);
    pulse_start(32'h10F8, 16'd1, 16'd8);
    wait_done("after_rst");

    // Start while busy is ignored.
    push_read(32'h1020, 1'b0); push_read(32'h1022, 1'b0);
    push_read(32'h1024, 1'b1);
    err_q.push_back(1'b0);
    d0 = done_cnt;
    pulse_start(32'h1020, 16'd0, 16'd3);
    pulse_start(32'h2000, 16'd5, 16'd5);
    wait_done("busy_start");
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_done_count", 64'(done_cnt - d0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
